// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage feeding decode and the next-PC stage.
// Issues word fetches over a req/gnt/rvalid interface, queues returned words
// with their PCs in an in-order FIFO, and flushes on redirect from next-PC.
// Optional build macro: FETCH_ALIGN_CHECK_EN adds the sticky addr_err output
// flagging redirects to non-word-aligned targets.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int          QDEPTH   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] npc,
  input  logic        redirect,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        addr_err
`endif
);

  localparam logic [3:0] QD   = 4'(QDEPTH);
  localparam logic [1:0] LAST = 2'(QDEPTH - 1);

  logic [31:0] fetch_pc;
  logic [31:0] resp_pc;
  logic [31:0] npc_al;
  logic [2:0]  inflight;
  logic [2:0]  inflight_nxt;
  logic [2:0]  drop;
  logic [2:0]  count;
  logic [3:0]  used;
  logic [1:0]  rd_ptr;
  logic [1:0]  wr_ptr;
  logic        fire;
  logic        rv_ok;
  logic        push;
  logic        pop;
  logic [31:0] q_inst [4];
  logic [31:0] q_pc   [4];

  // Circular pointer advance for a queue of QDEPTH entries (not a power of two in general).
  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LAST) ? 2'd0 : p + 2'd1;
  endfunction

  // Handshake decode, issue credit and next-state helpers.
  // A pop this cycle frees its slot immediately, so a streaming queue with
  // QDEPTH=2 sustains one instruction per cycle without overflowing.
  always_comb begin
    npc_al       = npc & 32'hFFFF_FFFC;
    imem_addr    = fetch_pc;
    inst_valid   = (count != 3'd0);
    pop          = inst_valid && inst_ready;
    used         = {1'b0, inflight} + {1'b0, count} - {3'b000, pop};
    imem_req     = rst_n && !redirect && (used < QD);
    fire         = imem_req && imem_gnt;
    rv_ok        = imem_rvalid && (inflight != 3'd0);
    push         = rv_ok && (drop == 3'd0) && !redirect;
    inflight_nxt = inflight + {2'b00, fire} - {2'b00, rv_ok};
    inst         = inst_valid ? q_inst[rd_ptr] : 32'h0;
    inst_pc      = inst_valid ? q_pc[rd_ptr]   : 32'h0;
  end

  // Control state: PCs, outstanding/drop counters, queue pointers; redirect flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      resp_pc  <= RESET_PC;
      inflight <= 3'd0;
      drop     <= 3'd0;
      count    <= 3'd0;
      rd_ptr   <= 2'd0;
      wr_ptr   <= 2'd0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect) begin
        fetch_pc <= npc_al;
        resp_pc  <= npc_al;
        drop     <= inflight_nxt;
        count    <= 3'd0;
        rd_ptr   <= 2'd0;
        wr_ptr   <= 2'd0;
      end else begin
        if (fire) fetch_pc <= fetch_pc + 32'd4;
        if (rv_ok && (drop != 3'd0)) drop <= drop - 3'd1;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr_ptr  <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + {2'b00, push} - {2'b00, pop};
      end
    end
  end

  // Queue storage; contents are only visible through the valid-masked head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_inst[wr_ptr] <= imem_rdata;
      q_pc[wr_ptr]   <= resp_pc;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky flag for redirects whose target is not word aligned.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_err <= 1'b0;
    end else if (redirect && (npc[1:0] != 2'b00)) begin
      addr_err <= 1'b1;
    end
  end
`endif

endmodule
